// File: rtl/seq_detect_ctrl_if.sv
// ----------------------------------------------------------------------------
// seq_detect_ctrl_if
// Serial bit-stream handshake between a bit source (master) and the
// pattern-detection controller (slave).
//
// Handshake: a bit transfers on a rising clk edge where bit_valid and
// bit_ready are both high. bit_valid must not depend on bit_ready, and
// bit_in is only meaningful while bit_valid is high.
//
// Signals:
//   bit_valid  master -> slave  bit_in carries a valid bit
//   bit_in     master -> slave  serial data bit
//   bit_ready  slave  -> master slave can accept a bit this cycle
// ----------------------------------------------------------------------------
interface seq_detect_ctrl_if;
    logic bit_valid;
    logic bit_in;
    logic bit_ready;

    modport master (
        output bit_valid,
        output bit_in,
        input  bit_ready
    );

    modport slave (
        input  bit_valid,
        input  bit_in,
        output bit_ready
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// ----------------------------------------------------------------------------
// seq_detect_ctrl
// Run-time programmable serial pattern detector. Matches a 1..MAXLEN bit
// pattern (first received bit is pattern[len-1]) in overlapping or
// non-overlapping mode, counts matches (saturating) and stops accepting bits
// once a programmed match threshold is reached (threshold 0 = never stop).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_cfg_pattern      pattern bits
//   i_cfg_len          pattern length, legal 1..MAXLEN
//   i_cfg_overlap      1 = overlapping matches, 0 = history cleared per match
//   i_cfg_threshold    match count that ends the scan, 0 = unlimited
//   i_start            pulse: latch config, clear count, begin scanning
//   i_abort            return to IDLE, wins over i_start
//   bit_if             serial bit handshake (slave side)
//   o_match            one-cycle pulse per detected match
//   o_match_count      matches since last accepted start, saturating
//   o_busy             high while scanning
//   o_done             high once the threshold has been reached
//   o_state            current FSM state, for observation
// ----------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int MAXLEN = 8,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MAXLEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]  i_cfg_len,
    input  logic              i_cfg_overlap,
    input  logic [CNT_W-1:0]  i_cfg_threshold,
    input  logic              i_start,
    input  logic              i_abort,
    seq_detect_ctrl_if.slave  bit_if,
    output logic              o_match,
    output logic [CNT_W-1:0]  o_match_count,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_n;

    // Shadow configuration, captured on an accepted start
    logic [MAXLEN-1:0] r_pat;
    logic [LEN_W-1:0]  r_len;
    logic              r_ovl;
    logic [CNT_W-1:0]  r_thr;

    logic [MAXLEN-1:0] r_hist;
    logic [LEN_W-1:0]  r_fill;

    logic [MAXLEN-1:0] w_hist_n;
    logic [LEN_W-1:0]  w_fill_n;
    logic [CNT_W-1:0]  w_cnt_n;
    logic              w_start_ok;
    logic              w_restart;
    logic              w_accept;
    logic              w_cmp_ok;
    logic              w_hit;
    logic              w_hit_acc;
    logic              w_match_n;
    logic              w_busy_n;
    logic              w_done_n;

    assign bit_if.bit_ready = (r_state == S_SCAN);
    assign o_state          = r_state;

    assign w_start_ok = i_start && (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAXLEN));
    // start is only honoured outside SCAN, and abort overrides it
    assign w_restart  = w_start_ok && !i_abort && (r_state != S_SCAN);
    assign w_accept   = bit_if.bit_valid && bit_if.bit_ready;

    assign w_hist_n = {r_hist[MAXLEN-2:0], bit_if.bit_in};
    assign w_fill_n = (r_fill >= r_len) ? r_len : r_fill + 1'b1;
    assign w_cnt_n  = (&o_match_count) ? o_match_count : o_match_count + 1'b1;

    // Compare only the low r_len bits of the updated history
    always_comb begin
        w_cmp_ok = 1'b1;
        for (int i = 0; i < MAXLEN; i++) begin
            if ((LEN_W'(i) < r_len) && (w_hist_n[i] != r_pat[i])) begin
                w_cmp_ok = 1'b0;
            end
        end
    end

    assign w_hit     = w_cmp_ok && (w_fill_n == r_len);
    // A bit handed over in an abort cycle is discarded
    assign w_hit_acc = w_accept && w_hit && !i_abort;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        if (i_abort) begin
            w_state_n = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_start_ok) w_state_n = S_SCAN;
                S_SCAN: if (w_hit_acc && (r_thr != '0) && (w_cnt_n == r_thr)) w_state_n = S_DONE;
                S_DONE: if (w_start_ok) w_state_n = S_SCAN;
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        w_match_n = w_hit_acc;
        w_busy_n  = (w_state_n == S_SCAN);
        w_done_n  = (w_state_n == S_DONE);
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_match       <= 1'b0;
            o_match_count <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            r_pat         <= '0;
            r_len         <= '0;
            r_ovl         <= 1'b0;
            r_thr         <= '0;
            r_hist        <= '0;
            r_fill        <= '0;
        end else begin
            o_match <= w_match_n;
            o_busy  <= w_busy_n;
            o_done  <= w_done_n;
            if (w_restart) begin
                r_pat         <= i_cfg_pattern;
                r_len         <= i_cfg_len;
                r_ovl         <= i_cfg_overlap;
                r_thr         <= i_cfg_threshold;
                r_hist        <= '0;
                r_fill        <= '0;
                o_match_count <= '0;
            end else if (w_accept && !i_abort) begin
                if (w_hit) begin
                    o_match_count <= w_cnt_n;
                    r_hist        <= r_ovl ? w_hist_n : '0;
                    r_fill        <= r_ovl ? w_fill_n : '0;
                end else begin
                    r_hist <= w_hist_n;
                    r_fill <= w_fill_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_detect_ctrl
// Directed table-driven bench for seq_detect_ctrl (MAXLEN=8). Each table row
// holds the inputs for one clock cycle and the outputs expected right after
// that cycle's rising edge. Mid-cycle reset and counter saturation are
// exercised by hand-written sequences.
// ----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_threshold;
    logic       start;
    logic       abort;
    logic       match;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic [1:0] state;

    seq_detect_ctrl_if bit_if ();

    seq_detect_ctrl #(.MAXLEN(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_cfg_pattern   (cfg_pattern),
        .i_cfg_len       (cfg_len),
        .i_cfg_overlap   (cfg_overlap),
        .i_cfg_threshold (cfg_threshold),
        .i_start         (start),
        .i_abort         (abort),
        .bit_if          (bit_if.slave),
        .o_match         (match),
        .o_match_count   (match_count),
        .o_busy          (busy),
        .o_done          (done),
        .o_state         (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       start;
        logic       abort;
        logic       valid;
        logic       bitv;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic [7:0] thr;
        logic       e_match;
        logic [7:0] e_count;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vec_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic add_row(input logic st, input logic ab, input logic v, input logic b,
                           input logic [7:0] p, input logic [3:0] l, input logic o,
                           input logic [7:0] t, input logic em, input logic [7:0] ec,
                           input logic eb, input logic ed);
        vec_t r;
        r.start = st; r.abort = ab; r.valid = v; r.bitv = b;
        r.pat = p; r.len = l; r.ovl = o; r.thr = t;
        r.e_match = em; r.e_count = ec; r.e_busy = eb; r.e_done = ed;
        vec_q.push_back(r);
    endtask

    task automatic add_start(input logic [7:0] p, input logic [3:0] l, input logic o,
                             input logic [7:0] t, input logic [7:0] ec,
                             input logic eb, input logic ed);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, p, l, o, t, 1'b0, ec, eb, ed);
    endtask

    // Config inputs carry junk during bit rows; shadow regs must ignore them
    task automatic add_bit(input logic v, input logic b, input logic em,
                           input logic [7:0] ec, input logic eb, input logic ed);
        add_row(1'b0, 1'b0, v, b, 8'h5A, 4'd2, 1'b0, 8'd1, em, ec, eb, ed);
    endtask

    task automatic add_abort(input logic [7:0] ec);
        add_row(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'd0, 1'b0, ec, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic em, input logic [7:0] ec,
                             input logic eb, input logic ed);
        check("match", idx, 32'(match), 32'(em));
        check("match_count", idx, 32'(match_count), 32'(ec));
        check("busy", idx, 32'(busy), 32'(eb));
        check("done", idx, 32'(done), 32'(ed));
        check("bit_ready", idx, 32'(bit_if.bit_ready), 32'(eb));
    endtask

    task automatic drive_idle();
        start = 1'b0; abort = 1'b0;
        bit_if.bit_valid = 1'b0; bit_if.bit_in = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; cfg_threshold = 8'd0;
    endtask

    task automatic apply_row(input vec_t r);
        start = r.start; abort = r.abort;
        bit_if.bit_valid = r.valid; bit_if.bit_in = r.bitv;
        cfg_pattern = r.pat; cfg_len = r.len; cfg_overlap = r.ovl; cfg_threshold = r.thr;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] exp_cnt;
        logic [6:0] stream;

        // Table: stream 1,1,0,1,1,0,1 (first bit = stream[6])
        stream = 7'b1101101;

        // Overlapping, no threshold: matches after bits 4 and 7
        add_start(8'b1101, 4'd4, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0);
        add_bit(1, 1, 0, 8'd0, 1, 0);
        add_bit(1, 1, 0, 8'd0, 1, 0);
        add_bit(1, 0, 0, 8'd0, 1, 0);
        add_bit(1, 1, 1, 8'd1, 1, 0);
        add_bit(1, 1, 0, 8'd1, 1, 0);
        add_bit(1, 0, 0, 8'd1, 1, 0);
        add_bit(1, 1, 1, 8'd2, 1, 0);
        add_bit(0, 0, 0, 8'd2, 1, 0);
        add_abort(8'd2);                                   // count retained
        // Illegal lengths in IDLE: ignored, count untouched
        add_start(8'b1101, 4'd0, 1'b1, 8'd0, 8'd2, 1'b0, 1'b0);
        add_start(8'b1101, 4'd9, 1'b1, 8'd0, 8'd2, 1'b0, 1'b0);

        // Non-overlapping: single match after bit 4
        add_start(8'b1101, 4'd4, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        for (int i = 6; i >= 0; i--)
            add_bit(1, stream[i], (i == 3), (i <= 3) ? 8'd1 : 8'd0, 1, 0);
        add_abort(8'd1);

        // Threshold 2: DONE with the second match, trailing bits refused
        add_start(8'b1101, 4'd4, 1'b1, 8'd2, 8'd0, 1'b1, 1'b0);
        add_bit(1, 1, 0, 8'd0, 1, 0);
        add_bit(1, 1, 0, 8'd0, 1, 0);
        add_bit(1, 0, 0, 8'd0, 1, 0);
        add_bit(1, 1, 1, 8'd1, 1, 0);
        add_bit(1, 1, 0, 8'd1, 1, 0);
        add_bit(1, 0, 0, 8'd1, 1, 0);
        add_bit(1, 1, 1, 8'd2, 0, 1);
        for (int i = 0; i < 4; i++) add_bit(1, 1, 0, 8'd2, 0, 1);
        add_start(8'b1101, 4'd0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b1);   // illegal start in DONE
        add_abort(8'd2);

        // Same with bit_valid low every other cycle (bit_in toggled junk)
        add_start(8'b1101, 4'd4, 1'b1, 8'd2, 8'd0, 1'b1, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            exp_cnt = (i <= 0) ? 8'd2 : (i <= 3) ? 8'd1 : 8'd0;
            add_bit(1, stream[i], (i == 3) || (i == 0), exp_cnt, (i != 0), (i == 0));
            add_bit(0, ~stream[i], 0, exp_cnt, (i != 0), (i == 0));
        end
        // Legal restart straight from DONE
        add_start(8'b1101, 4'd4, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0);
        // Abort after bit 3: no match, count held
        add_bit(1, 1, 0, 8'd0, 1, 0);
        add_bit(1, 1, 0, 8'd0, 1, 0);
        add_bit(1, 0, 0, 8'd0, 1, 0);
        add_abort(8'd0);
        add_bit(1, 1, 0, 8'd0, 0, 0);                      // not accepted in IDLE

        // ---- reset ----
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all(-1, 0, 8'd0, 0, 0);
        check("state", -1, 32'(state), 32'd0);
        rst = 1'b0;

        // ---- table ----
        foreach (vec_q[k]) begin
            apply_row(vec_q[k]);
            @(posedge clk);
            #1;
            check_all(k, vec_q[k].e_match, vec_q[k].e_count, vec_q[k].e_busy, vec_q[k].e_done);
        end

        // ---- asynchronous reset mid-cycle, with a match pending in outputs ----
        apply_row('{1, 0, 0, 0, 8'b11, 4'd2, 1'b1, 8'd0, 0, 8'd0, 0, 0});
        @(posedge clk); #1;
        drive_idle();
        bit_if.bit_valid = 1'b1; bit_if.bit_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(1000, 1, 8'd1, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all(1001, 0, 8'd0, 0, 0);
        #3;
        rst = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        check_all(1002, 0, 8'd0, 0, 0);

        // ---- saturation: len=1, pat=1, 260 ones ----
        apply_row('{1, 0, 0, 0, 8'b1, 4'd1, 1'b0, 8'd0, 0, 8'd0, 0, 0});
        @(posedge clk); #1;
        check_all(2000, 0, 8'd0, 1, 0);
        drive_idle();
        bit_if.bit_valid = 1'b1; bit_if.bit_in = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            @(posedge clk); #1;
            check_all(2000 + i, 1, (i > 255) ? 8'd255 : 8'(i), 1, 0);
        end
        bit_if.bit_valid = 1'b0;
        @(posedge clk); #1;
        check_all(2300, 0, 8'd255, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
